// File: rtl/hdr_bit_packer_if.sv
// hdr_bit_packer_if: header field input stream and AXI-Stream byte-beat output of the J2K header packer
interface hdr_bit_packer_if #(
  parameter int DATA_W    = 128,
  parameter int IN_W      = 32,
  parameter int BIT_CNT_W = 6
);
  localparam int KEEP_W = DATA_W / 8;
  logic                 s_hdr_valid;
  logic                 s_hdr_last;
  logic [1:0]           s_hdr_mode;
  logic [BIT_CNT_W-1:0] s_hdr_cnt;
  logic [IN_W-1:0]      s_hdr_data;
  logic                 s_hdr_ready;
  logic                 m_axis_hdr_tx_valid;
  logic                 m_axis_hdr_tx_last;
  logic [DATA_W-1:0]    m_axis_hdr_tx_data;
  logic [KEEP_W-1:0]    m_axis_hdr_tx_keep;
  logic                 m_axis_hdr_tx_ready;
  modport master (
    output s_hdr_valid, s_hdr_last, s_hdr_mode, s_hdr_cnt, s_hdr_data, m_axis_hdr_tx_ready,
    input  s_hdr_ready, m_axis_hdr_tx_valid, m_axis_hdr_tx_last, m_axis_hdr_tx_data, m_axis_hdr_tx_keep
  );
  modport slave (
    input  s_hdr_valid, s_hdr_last, s_hdr_mode, s_hdr_cnt, s_hdr_data, m_axis_hdr_tx_ready,
    output s_hdr_ready, m_axis_hdr_tx_valid, m_axis_hdr_tx_last, m_axis_hdr_tx_data, m_axis_hdr_tx_keep
  );
endinterface

// File: rtl/hdr_bit_packer.sv
// hdr_bit_packer: packs MSB-first header fields and runs into J2K bit-stuffed bytes grouped into AXIS beats
module hdr_bit_packer #(
  parameter int DATA_W     = 128,
  parameter int IN_W       = 32,
  parameter int BIT_CNT_W  = 6,
  parameter bit STUFF_EN   = 1'b1,
  parameter bit TERM_FF_EN = 1'b1
) (
  input  logic            clk,
  input  logic            rst,
  hdr_bit_packer_if.slave bus,
  output logic            cnt_err
);
  localparam int KEEP_W = DATA_W / 8;
  localparam int LANE_W = $clog2(KEEP_W + 1);
  typedef enum logic [1:0] {IDLE, PACK, FLUSH, TERM} state_t;
  state_t               state, state_nx;
  logic                 live, lst, ff;
  logic [1:0]           md;
  logic [BIT_CNT_W-1:0] left, cnt_eff;
  logic [IN_W-1:0]      dat;
  logic [7:0]           acc, acc_nx, chunk, mask, st_byte;
  logic [3:0]           fill, room, n;
  logic                 in_data, accept, out_free, buf_full, full, partial;
  logic                 st_req, st_ok, fin, fin_ok, go;
  logic [DATA_W-1:0]    wbuf, out_data;
  logic [LANE_W-1:0]    wcnt;
  logic [KEEP_W:0]      fin_keep;
  logic                 out_valid, out_last;
  logic [KEEP_W-1:0]    out_keep;
  assign bus.s_hdr_ready         = live && state == IDLE;
  assign bus.m_axis_hdr_tx_valid = out_valid;
  assign bus.m_axis_hdr_tx_last  = out_last;
  assign bus.m_axis_hdr_tx_data  = out_data;
  assign bus.m_axis_hdr_tx_keep  = out_keep;
  // fill counts occupied bit slots; a byte after 0xFF starts at 1 with its MSB held at 0
  always_comb begin
    in_data  = bus.s_hdr_mode[0] == bus.s_hdr_mode[1];
    cnt_eff  = (in_data && bus.s_hdr_cnt > BIT_CNT_W'(IN_W)) ? BIT_CNT_W'(IN_W) : bus.s_hdr_cnt;
    accept   = live && state == IDLE && bus.s_hdr_valid;
    out_free = !out_valid || bus.m_axis_hdr_tx_ready;
    buf_full = wcnt == LANE_W'(KEEP_W);
    room     = 4'd8 - fill;
    n        = state != PACK ? 4'd0 : (left < BIT_CNT_W'(room)) ? 4'(left) : room;
    mask     = 8'hFF >> (4'd8 - n);
    chunk    = md == 2'b01 ? 8'h00 : md == 2'b10 ? mask : 8'(dat >> (left - BIT_CNT_W'(n))) & mask;
    acc_nx   = acc | (chunk << (4'd8 - fill - n));
    full     = fill + n == 4'd8;
    partial  = fill != {3'd0, STUFF_EN && ff};
    fin      = state == FLUSH && !partial && !(TERM_FF_EN && ff);
    st_req   = (state == PACK && full) || (state == FLUSH && partial) || state == TERM;
    st_byte  = state == PACK ? acc_nx : state == FLUSH ? acc : 8'h00;
    st_ok    = !buf_full || out_free;
    fin_ok   = wcnt == '0 || out_free;
    go       = st_req ? st_ok : fin ? fin_ok : 1'b1;
    fin_keep = ({{KEEP_W{1'b0}}, 1'b1} << wcnt) - (KEEP_W + 1)'(1);
    state_nx = state;
    case (state)
      IDLE:    state_nx = !accept ? IDLE : cnt_eff != '0 ? PACK : bus.s_hdr_last ? FLUSH : IDLE;
      PACK:    state_nx = !(go && left == BIT_CNT_W'(n)) ? PACK : lst ? FLUSH : IDLE;
      FLUSH:   state_nx = partial ? FLUSH : (TERM_FF_EN && ff) ? TERM : fin_ok ? IDLE : FLUSH;
      default: state_nx = st_ok ? FLUSH : TERM;
    endcase
  end
  always_ff @(posedge clk or posedge rst)
    if (rst) state <= IDLE;
    else state <= state_nx;
  // a full word is only pushed out when another byte needs its lanes, so a
  // header ending exactly on a word boundary leaves that word for the last beat
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      live      <= 1'b0;
      lst       <= 1'b0;
      md        <= '0;
      left      <= '0;
      dat       <= '0;
      acc       <= '0;
      fill      <= '0;
      ff        <= 1'b0;
      wbuf      <= '0;
      wcnt      <= '0;
      out_valid <= 1'b0;
      out_last  <= 1'b0;
      out_keep  <= '0;
      out_data  <= '0;
      cnt_err   <= 1'b0;
    end else begin
      live <= 1'b1;
      if (out_valid && bus.m_axis_hdr_tx_ready) out_valid <= 1'b0;
      if (accept) begin
        md      <= bus.s_hdr_mode;
        left    <= cnt_eff;
        dat     <= bus.s_hdr_data;
        lst     <= bus.s_hdr_last;
        cnt_err <= cnt_err || cnt_eff != bus.s_hdr_cnt;
      end
      if (state == PACK && go) begin
        left <= left - BIT_CNT_W'(n);
        acc  <= acc_nx;
        fill <= fill + n;
      end
      if (st_req && st_ok) begin
        acc  <= '0;
        fill <= {3'd0, STUFF_EN && st_byte == 8'hFF};
        ff   <= st_byte == 8'hFF;
        if (buf_full) begin
          out_valid <= 1'b1;
          out_last  <= 1'b0;
          out_keep  <= '1;
          out_data  <= wbuf;
          wbuf      <= {{(DATA_W-8){1'b0}}, st_byte};
          wcnt      <= LANE_W'(1);
        end else begin
          wbuf[8*wcnt +: 8] <= st_byte;
          wcnt              <= wcnt + LANE_W'(1);
        end
      end
      if (fin && fin_ok) begin
        if (wcnt != '0) begin
          out_valid <= 1'b1;
          out_last  <= 1'b1;
          out_keep  <= fin_keep[KEEP_W-1:0];
          out_data  <= wbuf;
        end
        wbuf <= '0;
        wcnt <= '0;
        acc  <= '0;
        fill <= '0;
        ff   <= 1'b0;
      end
    end
  end
endmodule

// File: tb/tb_hdr_bit_packer.sv
// tb_hdr_bit_packer: randomized scoreboard bench for hdr_bit_packer with directed header cases
module tb_hdr_bit_packer;
  localparam int DATA_W = 128, KEEP_W = 16, IN_W = 32, CW = 6;
  typedef struct {
    logic [DATA_W-1:0] data;
    logic [KEEP_W-1:0] keep;
    logic              last;
  } beat_t;
  logic clk = 1'b0, rst = 1'b1, cnt_err, cnt_err2;
  int checks = 0, errors = 0;
  bit auto_exp = 1'b1, hold = 1'b0;
  beat_t exp_q[$];
  logic [7:0] mb[$];
  logic [7:0] mcur = 8'h00;
  int mpos = 0;
  bit mpf = 1'b0;
  hdr_bit_packer_if #(.DATA_W(DATA_W), .IN_W(IN_W), .BIT_CNT_W(CW)) bus ();
  hdr_bit_packer_if #(.DATA_W(DATA_W), .IN_W(IN_W), .BIT_CNT_W(CW)) bus2 ();
  hdr_bit_packer #(.DATA_W(DATA_W), .IN_W(IN_W), .BIT_CNT_W(CW), .STUFF_EN(1'b1), .TERM_FF_EN(1'b1))
    dut (.clk(clk), .rst(rst), .bus(bus), .cnt_err(cnt_err));
  hdr_bit_packer #(.DATA_W(DATA_W), .IN_W(IN_W), .BIT_CNT_W(CW), .STUFF_EN(1'b1), .TERM_FF_EN(1'b0))
    dut2 (.clk(clk), .rst(rst), .bus(bus2), .cnt_err(cnt_err2));
  always #5 clk = ~clk;

  task automatic check(string name, logic [DATA_W-1:0] act, logic [DATA_W-1:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, req);
    end
  endtask

  function automatic logic [DATA_W-1:0] kmask(logic [KEEP_W-1:0] k);
    logic [DATA_W-1:0] r = '0;
    for (int i = 0; i < KEEP_W; i++) r[8*i +: 8] = {8{k[i]}};
    return r;
  endfunction

  // reference stream: bytes accumulate, a word leaves only once more bytes follow it
  function automatic void emit_beat(int len, bit last);
    beat_t e;
    logic [KEEP_W:0] k;
    e.data = '0;
    for (int i = 0; i < len; i++) e.data[8*i +: 8] = mb.pop_front();
    k = (17'd1 << len) - 17'd1;
    e.keep = k[KEEP_W-1:0];
    e.last = last;
    if (auto_exp) exp_q.push_back(e);
  endfunction

  function automatic void model_bit(bit v);
    if (mpos == 0 && mpf) mpos = 1;
    mcur[7-mpos] = v;
    mpos++;
    if (mpos == 8) begin
      mb.push_back(mcur);
      mpf = mcur == 8'hFF;
      mcur = 8'h00;
      mpos = 0;
    end
    if (mb.size() > KEEP_W) emit_beat(KEEP_W, 1'b0);
  endfunction

  function automatic void model_field(logic [1:0] m, int c, logic [31:0] d);
    bit dm = m[0] == m[1];
    int cc = (dm && c > IN_W) ? IN_W : c;
    for (int i = cc - 1; i >= 0; i--) model_bit(dm ? d[i] : m[1]);
  endfunction

  function automatic void model_end();
    if (mpos > 0) mb.push_back(mcur);
    if (mb.size() > 0 && mb[mb.size()-1] == 8'hFF) mb.push_back(8'h00);
    while (mb.size() > KEEP_W) emit_beat(KEEP_W, 1'b0);
    if (mb.size() > 0) emit_beat(mb.size(), 1'b1);
    mcur = 8'h00;
    mpos = 0;
    mpf = 1'b0;
  endfunction

  function automatic void model_reset();
    mb.delete();
    exp_q.delete();
    mcur = 8'h00;
    mpos = 0;
    mpf = 1'b0;
  endfunction

  function automatic void exp_beat(logic [DATA_W-1:0] d, logic [KEEP_W-1:0] k);
    exp_q.push_back('{d, k, 1'b1});
  endfunction

  task automatic send(logic [1:0] m, int c, logic [31:0] d, bit last);
    int t = 0;
    @(negedge clk);
    bus.s_hdr_valid = 1'b1;
    bus.s_hdr_mode  = m;
    bus.s_hdr_cnt   = CW'(c);
    bus.s_hdr_data  = d;
    bus.s_hdr_last  = last;
    while (!bus.s_hdr_ready && t < 300) begin
      @(negedge clk);
      t++;
    end
    if (t >= 300) check("accept_timeout", DATA_W'(bus.s_hdr_ready), DATA_W'(1));
    else begin
      @(posedge clk);
      model_field(m, c, d);
      if (last) model_end();
    end
    #1 bus.s_hdr_valid = 1'b0;
  endtask

  task automatic drain();
    int t = 0;
    while (exp_q.size() != 0 && t < 3000) begin
      @(negedge clk);
      t++;
    end
    check("drain_pending", DATA_W'(exp_q.size()), '0);
    repeat (5) @(negedge clk);
  endtask

  task automatic drive_ready();
    forever begin
      @(posedge clk);
      #1 bus.m_axis_hdr_tx_ready = !hold && ($urandom_range(0, 3) != 0);
    end
  endtask

  task automatic monitor();
    beat_t e, pv;
    bit pend = 1'b0;
    forever begin
      @(negedge clk);
      if (rst) pend = 1'b0;
      else begin
        if (pend) begin
          check("stall_valid", DATA_W'(bus.m_axis_hdr_tx_valid), DATA_W'(1));
          check("stall_data", bus.m_axis_hdr_tx_data, pv.data);
          check("stall_keep", DATA_W'(bus.m_axis_hdr_tx_keep), DATA_W'(pv.keep));
          check("stall_last", DATA_W'(bus.m_axis_hdr_tx_last), DATA_W'(pv.last));
        end
        pend = bus.m_axis_hdr_tx_valid && !bus.m_axis_hdr_tx_ready;
        pv.data = bus.m_axis_hdr_tx_data;
        pv.keep = bus.m_axis_hdr_tx_keep;
        pv.last = bus.m_axis_hdr_tx_last;
        if (bus.m_axis_hdr_tx_valid && bus.m_axis_hdr_tx_ready) begin
          if (exp_q.size() == 0) check("extra_beat", DATA_W'(bus.m_axis_hdr_tx_valid), '0);
          else begin
            e = exp_q.pop_front();
            check("beat_keep", DATA_W'(bus.m_axis_hdr_tx_keep), DATA_W'(e.keep));
            check("beat_last", DATA_W'(bus.m_axis_hdr_tx_last), DATA_W'(e.last));
            check("beat_data", bus.m_axis_hdr_tx_data & kmask(e.keep), e.data & kmask(e.keep));
          end
        end
      end
    end
  endtask

  initial begin
    int nf, c, t;
    logic [1:0] m;
    logic [31:0] d;
    bus.s_hdr_valid = 1'b0; bus.s_hdr_last = 1'b0; bus.s_hdr_mode = '0;
    bus.s_hdr_cnt = '0; bus.s_hdr_data = '0; bus.m_axis_hdr_tx_ready = 1'b0;
    bus2.s_hdr_valid = 1'b0; bus2.s_hdr_last = 1'b0; bus2.s_hdr_mode = '0;
    bus2.s_hdr_cnt = '0; bus2.s_hdr_data = '0; bus2.m_axis_hdr_tx_ready = 1'b1;
    fork
      monitor();
      drive_ready();
    join_none
    repeat (3) @(negedge clk);
    check("rst_ready", DATA_W'(bus.s_hdr_ready), '0);
    check("rst_valid", DATA_W'(bus.m_axis_hdr_tx_valid), '0);
    check("rst_cnt_err", DATA_W'(cnt_err), '0);
    rst = 1'b0;
    @(negedge clk);
    check("ready_after_rst", DATA_W'(bus.s_hdr_ready), DATA_W'(1));
    // the instance without 0xFF termination
    bus2.s_hdr_valid = 1'b1; bus2.s_hdr_mode = 2'b10; bus2.s_hdr_cnt = CW'(8); bus2.s_hdr_last = 1'b1;
    t = 0;
    while (!bus2.s_hdr_ready && t < 50) begin @(negedge clk); t++; end
    @(posedge clk);
    #1 bus2.s_hdr_valid = 1'b0;
    t = 0;
    do begin @(negedge clk); t++; end while (!bus2.m_axis_hdr_tx_valid && t < 50);
    check("noterm_valid", DATA_W'(bus2.m_axis_hdr_tx_valid), DATA_W'(1));
    check("noterm_data", DATA_W'(bus2.m_axis_hdr_tx_data[7:0]), DATA_W'(8'hFF));
    check("noterm_keep", DATA_W'(bus2.m_axis_hdr_tx_keep), DATA_W'(16'h0001));
    check("noterm_last", DATA_W'(bus2.m_axis_hdr_tx_last), DATA_W'(1));
    // directed headers with hand-computed bytes
    auto_exp = 1'b0;
    exp_beat(128'h40FF, 16'h0003);
    send(2'b00, 8, 32'hFF, 1'b0);
    send(2'b00, 1, 32'h1, 1'b1);
    exp_beat(128'h00FF, 16'h0003);
    send(2'b10, 8, 32'h0, 1'b1);
    exp_beat({16{8'h55}}, 16'hFFFF);
    for (int i = 0; i < 16; i++) send(2'b00, 8, 32'h55, i == 15);
    exp_beat(128'hE0_0000000000, 16'h003F);
    send(2'b01, 40, 32'h0, 1'b0);
    send(2'b10, 3, 32'h0, 1'b1);
    drain();
    auto_exp = 1'b1;
    send(2'b00, 40, $urandom, 1'b1);
    send(2'b00, 0, 32'h0, 1'b1);
    drain();
    check("cnt_err_sticky", DATA_W'(cnt_err), DATA_W'(1));
    fork
      begin
        hold = 1'b1;
        repeat (20) @(posedge clk);
        hold = 1'b0;
      end
    join_none
    for (int i = 0; i < 12; i++) send(2'b11, 32, $urandom, i == 11);
    drain();
    for (int p = 0; p < 80; p++) begin
      nf = $urandom_range(1, 5);
      for (int f = 0; f < nf; f++) begin
        m = 2'($urandom_range(0, 3));
        c = (m[0] == m[1]) ? $urandom_range(0, 34) : $urandom_range(0, 63);
        d = ($urandom_range(0, 3) == 0) ? 32'hFFFFFFFF : $urandom;
        send(m, c, d, f == nf - 1);
      end
    end
    drain();
    // reset while packing with three bytes sitting in the word buffer
    for (int i = 0; i < 3; i++) send(2'b00, 8, 32'h11 * (i + 1), 1'b0);
    send(2'b00, 32, $urandom, 1'b0);
    @(negedge clk);
    rst = 1'b1;
    #1;
    model_reset();
    check("midrst_valid", DATA_W'(bus.m_axis_hdr_tx_valid), '0);
    check("midrst_last", DATA_W'(bus.m_axis_hdr_tx_last), '0);
    check("midrst_keep", DATA_W'(bus.m_axis_hdr_tx_keep), '0);
    check("midrst_data", bus.m_axis_hdr_tx_data, '0);
    check("midrst_ready", DATA_W'(bus.s_hdr_ready), '0);
    check("midrst_cnt_err", DATA_W'(cnt_err), '0);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    auto_exp = 1'b0;
    exp_beat(128'hA5, 16'h0001);
    send(2'b00, 8, 32'hA5, 1'b1);
    drain();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
